// File: rtl/pll0_reset_seq.sv
// Camera PLL reset sequencer: supervises PLL lock on the reference clock, retries on
// lock timeout, then releases the camera reset and the VIP/system reset in order.
module pll0_reset_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_FILTER    = 256,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int CAM_DELAY      = 2048,
  parameter int CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  output logic             pll_rst,
  output logic             cam_reset_n,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam int PW = $clog2(PLL_RST_CYCLES) + 1;
  localparam int FW = $clog2(LOCK_FILTER) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int DW = $clog2(CAM_DELAY) + 1;

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_CAM_REL   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_sync;
  logic             w_lock_s;
  logic [PW-1:0]    r_pcnt;
  logic [FW-1:0]    r_filt;
  logic [TW-1:0]    r_tmo;
  logic [TW-1:0]    w_tmo_inc;
  logic [DW-1:0]    r_dcnt;
  logic             w_retry_inc;
  logic             w_loss_inc;
  logic             w_pll_rst;
  logic             w_cam_reset_n;
  logic             w_sys_rst;
  logic             w_ready;
  logic             r_pll_rst;
  logic             r_cam_reset_n;
  logic             r_sys_rst;
  logic             r_ready;
  logic [CNT_W-1:0] r_retry_cnt;
  logic [CNT_W-1:0] r_loss_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign w_lock_s  = r_sync[1];
  assign w_tmo_inc = r_tmo + TW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_retry_inc = 1'b0;
    w_loss_inc  = 1'b0;
    case (r_state)
      S_PLL_RST: begin
        if (r_pcnt == PW'(PLL_RST_CYCLES)) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // A filter hit outranks a timeout landing on the same cycle.
        if (r_filt == FW'(LOCK_FILTER)) begin
          w_state_nxt = S_CAM_REL;
        end else if (w_tmo_inc == TW'(LOCK_TIMEOUT)) begin
          w_state_nxt = S_PLL_RST;
          w_retry_inc = 1'b1;
        end
      end
      S_CAM_REL: begin
        if (!w_lock_s) begin
          w_state_nxt = S_PLL_RST;
          w_loss_inc  = 1'b1;
        end else if (r_dcnt == DW'(CAM_DELAY)) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = S_PLL_RST;
          w_loss_inc  = 1'b1;
        end
      end
      default: w_state_nxt = S_PLL_RST;
    endcase
  end

  always_comb begin
    w_pll_rst     = 1'b0;
    w_cam_reset_n = 1'b0;
    w_sys_rst     = 1'b1;
    w_ready       = 1'b0;
    case (w_state_nxt)
      S_PLL_RST:   w_pll_rst = 1'b1;
      S_WAIT_LOCK: w_pll_rst = 1'b0;
      S_CAM_REL:   w_cam_reset_n = 1'b1;
      S_RUN: begin
        w_cam_reset_n = 1'b1;
        w_sys_rst     = 1'b0;
        w_ready       = 1'b1;
      end
      default:     w_pll_rst = 1'b1;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state       <= S_PLL_RST;
      r_sync        <= 2'b00;
      r_pcnt        <= '0;
      r_filt        <= '0;
      r_tmo         <= '0;
      r_dcnt        <= '0;
      r_pll_rst     <= 1'b1;
      r_cam_reset_n <= 1'b0;
      r_sys_rst     <= 1'b1;
      r_ready       <= 1'b0;
      r_retry_cnt   <= '0;
      r_loss_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_sync        <= {r_sync[0], locked};
      r_pll_rst     <= w_pll_rst;
      r_cam_reset_n <= w_cam_reset_n;
      r_sys_rst     <= w_sys_rst;
      r_ready       <= w_ready;
      if (w_retry_inc) r_retry_cnt <= sat_inc(r_retry_cnt);
      if (w_loss_inc)  r_loss_cnt  <= sat_inc(r_loss_cnt);

      // Entering a timed state counts the entry cycle itself as the first one.
      if (w_state_nxt == S_PLL_RST)
        r_pcnt <= (r_state == S_PLL_RST) ? r_pcnt + PW'(1) : PW'(1);
      else
        r_pcnt <= '0;

      if (r_state == S_WAIT_LOCK && w_state_nxt == S_WAIT_LOCK) begin
        r_filt <= w_lock_s ? r_filt + FW'(1) : '0;
        r_tmo  <= w_tmo_inc;
      end else begin
        r_filt <= '0;
        r_tmo  <= '0;
      end

      if (w_state_nxt == S_CAM_REL)
        r_dcnt <= (r_state == S_CAM_REL) ? r_dcnt + DW'(1) : DW'(1);
      else
        r_dcnt <= '0;
    end
  end

  assign pll_rst     = r_pll_rst;
  assign cam_reset_n = r_cam_reset_n;
  assign sys_rst     = r_sys_rst;
  assign ready       = r_ready;
  assign retry_cnt   = r_retry_cnt;
  assign loss_cnt    = r_loss_cnt;

endmodule

// File: tb/tb_pll0_reset_seq.sv
// Directed bench for pll0_reset_seq: expected output vectors are queued per edge
// number and compared when the run reaches that edge.
module tb_pll0_reset_seq;

  logic       clk;
  logic       rst;
  logic       locked;
  logic       pll_rst;
  logic       cam_reset_n;
  logic       sys_rst;
  logic       ready;
  logic [1:0] retry_cnt;
  logic [1:0] loss_cnt;

  pll0_reset_seq #(
    .PLL_RST_CYCLES(4),
    .LOCK_FILTER   (8),
    .LOCK_TIMEOUT  (64),
    .CAM_DELAY     (16),
    .CNT_W         (2)
  ) dut (
    .refclk     (clk),
    .rst        (rst),
    .locked     (locked),
    .pll_rst    (pll_rst),
    .cam_reset_n(cam_reset_n),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output-state codes {pll_rst, cam_reset_n, sys_rst, ready}
  localparam logic [3:0] O_PLL  = 4'b1010;
  localparam logic [3:0] O_WAIT = 4'b0010;
  localparam logic [3:0] O_CAM  = 4'b0110;
  localparam logic [3:0] O_RUN  = 4'b0101;

  typedef struct {
    int         e;
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_n  = -1;
  logic watch_rdy = 1'b0;
  logic saw_rdy   = 1'b0;

  function automatic logic [7:0] obs_vec();
    return {pll_rst, cam_reset_n, sys_rst, ready, retry_cnt, loss_cnt};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(input int e, input string tag, input logic [3:0] st,
                      input logic [1:0] rc, input logic [1:0] lc);
    exp_t it;
    it.e   = e;
    it.tag = tag;
    it.v   = {st, rc, lc};
    q.push_back(it);
  endtask

  task automatic tick();
    exp_t it;
    @(posedge clk);
    edge_n++;
    #1;
    if (watch_rdy && ready) saw_rdy = 1'b1;
    while (q.size() > 0 && q[0].e <= edge_n) begin
      it = q.pop_front();
      if (it.e < edge_n) begin
        n_tests++;
        n_fail++;
        $error("FAIL %s: expectation for edge %0d skipped at edge %0d", it.tag, it.e, edge_n);
      end else begin
        chk(it.tag, obs_vec(), it.v);
      end
    end
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  initial begin
    rst    = 1'b1;
    locked = 1'b0;
    repeat (3) tick();
    chk("reset_state", obs_vec(), {O_PLL, 2'd0, 2'd0});

    // Bring-up, loss in RUN, then a one-cycle reset while running.
    rst    = 1'b0;
    edge_n = -1;
    push(3,  "bringup_pll_hold",  O_PLL,  2'd0, 2'd0);
    push(4,  "bringup_pll_fall",  O_WAIT, 2'd0, 2'd0);
    push(23, "bringup_no_early",  O_WAIT, 2'd0, 2'd0);
    push(24, "bringup_cam_rel",   O_CAM,  2'd0, 2'd0);
    push(39, "bringup_cam_hold",  O_CAM,  2'd0, 2'd0);
    push(40, "bringup_run",       O_RUN,  2'd0, 2'd0);
    push(52, "loss_run_sync",     O_RUN,  2'd0, 2'd0);
    push(53, "loss_run_pll",      O_PLL,  2'd0, 2'd1);
    push(56, "relock_pll_hold",   O_PLL,  2'd0, 2'd1);
    push(57, "relock_wait",       O_WAIT, 2'd0, 2'd1);
    push(65, "relock_no_early",   O_WAIT, 2'd0, 2'd1);
    push(66, "relock_cam",        O_CAM,  2'd0, 2'd1);
    push(81, "relock_cam_hold",   O_CAM,  2'd0, 2'd1);
    push(82, "relock_run",        O_RUN,  2'd0, 2'd1);
    push(91, "midrun_reset",      O_PLL,  2'd0, 2'd0);
    run_to(13);
    locked = 1'b1;
    run_to(50);
    locked = 1'b0;
    run_to(53);
    locked = 1'b1;
    run_to(90);
    rst = 1'b1;
    tick();
    locked = 1'b0;
    tick();

    // Timeouts with retry saturation, lock-vs-timeout tie, loss in CAM_REL, glitchy lock.
    rst    = 1'b0;
    edge_n = -1;
    push(4,   "tmo_wait",          O_WAIT, 2'd0, 2'd0);
    push(67,  "tmo_not_yet",       O_WAIT, 2'd0, 2'd0);
    push(68,  "tmo_retry1",        O_PLL,  2'd1, 2'd0);
    push(71,  "tmo_pll_hold",      O_PLL,  2'd1, 2'd0);
    push(72,  "tmo_pll_fall",      O_WAIT, 2'd1, 2'd0);
    push(136, "tmo_retry2",        O_PLL,  2'd2, 2'd0);
    push(204, "tmo_retry3",        O_PLL,  2'd3, 2'd0);
    push(272, "tmo_retry_sat",     O_PLL,  2'd3, 2'd0);
    push(276, "tmo_wait_again",    O_WAIT, 2'd3, 2'd0);
    push(339, "tie_before",        O_WAIT, 2'd3, 2'd0);
    push(340, "tie_lock_wins",     O_CAM,  2'd3, 2'd0);
    push(347, "camloss_sync",      O_CAM,  2'd3, 2'd0);
    push(348, "camloss_pll",       O_PLL,  2'd3, 2'd1);
    push(352, "glitch_wait",       O_WAIT, 2'd3, 2'd1);
    push(370, "glitch_no_early",   O_WAIT, 2'd3, 2'd1);
    push(375, "glitch_hold",       O_WAIT, 2'd3, 2'd1);
    push(376, "glitch_cam",        O_CAM,  2'd3, 2'd1);
    run_to(329);
    locked = 1'b1;
    watch_rdy = 1'b1;
    run_to(345);
    locked = 1'b0;
    run_to(352);
    watch_rdy = 1'b0;
    chk("camloss_no_ready", {7'd0, saw_rdy}, 8'd0);
    run_to(359);
    locked = 1'b1;
    run_to(364);
    locked = 1'b0;
    run_to(365);
    locked = 1'b1;
    run_to(380);

    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_drain: %0d pending expectations, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
